premul_for_1213: RTL and testbench
==================================

// Module: premul_for_1213
// PURPOSE
//  Pipelined modular-multiply front end that sits directly upstream of the Barrett reducer for q=1213.
//  Accepts two residues a,b (11 bit) over a valid/ready handshake and computes the raw product a*b.
//  Emits the product as a 21-bit word on a valid/ready handshake; the word is the reducer's din_a input.
//  Two register stages, so the block sustains one product per cycle at full throughput.
// PARAMETERS
//  Q      1213  modulus; operands are defined in the range 0..Q-1
//  W      11    operand width; must satisfy Q <= 2**W
//  PW     21    product width = 2*W-1, sufficient because (Q-1)^2 = 1468944 < 2**21
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   reset; synchronous and active-low
//  in_valid     in   1   operand pair present on in_a/in_b
//  in_ready     out  1   block accepts the pair this cycle
//  in_a         in   W   operand a
//  in_b         in   W   operand b
//  out_valid    out  1   product present on out_p
//  out_ready    in   1   downstream (reducer wrapper) accepts the product
//  out_p        out  PW  a*b, unreduced
//  err_pulse    out  1   operand-range error strobe (see CONFIGURATION)
//  err_count    out  16  saturating count of range errors (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - s1_valid=0, s2_valid=0, out_valid=0, out_p=0, err_pulse=0, err_count=0.
//   - Any in-flight pair is discarded.
//   - in_ready=0 while rst_n=0.
//  Stage 1 (S1):
//   - Registers a and b.
//   - Registers partial products pl=a*b[5:0] (17 b) and ph=a*b[10:6] (16 b).
//  Stage 2 (S2):
//   - out_p <= pl + (ph<<6), truncated to PW; this truncation is exact for in-range operands.
//   - out_valid = s2_valid.
//  Handshake and advance:
//   - Transfer on a port occurs when valid&&ready are both high at the clk edge.
//   - adv2 = !s2_valid || out_ready.
//   - adv1 = !s1_valid || adv2.
//   - in_ready = adv1 (combinational, no dependence on in_valid).
//   - S2 loads from S1 when adv2; S1 loads from input when adv1.
//   - Bubbles collapse; a stage holds its contents while not advancing.
//  Latency: 2 cycles from input transfer to out_valid when unstalled.
//  Throughput: 1 pair per cycle; capacity 2 in-flight items.
//  Rules:
//   - out_p and out_valid stay stable while out_valid && !out_ready.
//   - Ordering is strictly FIFO.
//  Simultaneous events:
//   - A full pipe with out_ready=1 and in_valid=1 shifts all stages in the same cycle.
//   - No item is lost or duplicated.
//  Out-of-range operands: see CONFIGURATION; without the macro their products pass through (truncated to PW).
// CONFIGURATION
//  Macro PREMUL_RANGE_CHECK_EN.
//  Defined:
//   - An accepted pair with a>=Q or b>=Q is consumed (in_ready handshake completes) but enters S1 as a bubble.
//   - err_pulse=1 exactly one cycle after acceptance.
//   - err_count increments and saturates at 16'hFFFF.
//  Undefined:
//   - No check; err_pulse=0 and err_count=0 permanently.
//   - Port list is identical in both builds.
// STRUCTURE
//  Shared package galois_pkg:
//   - constants Q_1213=1213, W_1213=11, PW_1213=21.
//   - function in_range_1213(x).
//  One natural sub-module, premul_stage_reg: a valid+data register with an advance enable.
//   - Instantiated once for S1 and once for S2.
//  The arithmetic stays inline in the top module.
// TESTING
//  1. a=1212,b=1212, out_ready=1 -> out_p=1468944, out_valid=1 exactly 2 cycles after the transfer.
//  2. Back-to-back pairs (1,1),(2,3),(0,1000),(1212,1) with out_ready=1 -> 1,6,0,1212 on consecutive cycles.
//  3. out_ready=0 for 6 cycles, in_valid=1 throughout:
//     - in_ready drops after 2 accepts; out_p holds the first product.
//     - Releasing out_ready drains in order with no loss.
//  4. rst_n=0 for 1 cycle while out_valid=1 -> next cycle out_valid=0, err_count=0, in_ready=1 after reset release.
//  5. [PREMUL_RANGE_CHECK_EN] a=1213,b=5 accepted:
//     - err_pulse=1 one cycle later, err_count=1, no output beat.
//     - A following (2,2) outputs 4.
//  6. Chain to barret_for_1213: random in-range pairs -> reducer output == (a*b)%1213 for 10000 vectors.

Source files
------------

// File: rtl/galois_pkg.sv
// Shared constants, stage-1 payload layout and the operand range test for the q=1213 datapath.
package galois_pkg;

  localparam int unsigned Q_1213  = 1213;
  localparam int unsigned W_1213  = 11;
  localparam int unsigned PW_1213 = 21;

  // b is split at bit 6 so each partial product is a narrow multiply.
  localparam int unsigned B_SPLIT = 6;
  localparam int unsigned PL_W    = 17;
  localparam int unsigned PH_W    = 16;

  localparam logic [W_1213-1:0] Q_1213_W = 11'd1213;

  typedef struct packed {
    logic [W_1213-1:0] a;
    logic [W_1213-1:0] b;
    logic [PL_W-1:0]   pl;
    logic [PH_W-1:0]   ph;
  } s1_t;

  function automatic logic in_range_1213(input logic [W_1213-1:0] x);
    return x < Q_1213_W;
  endfunction

endpackage

// File: rtl/premul_stage_reg.sv
// One pipeline stage: a valid bit plus a data word, loaded only when the stage advances.
module premul_stage_reg #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          d_valid,
  input  logic [DW-1:0] d,
  output logic          q_valid,
  output logic [DW-1:0] q
);

  // NOTE: non-blocking assignments keep every stage sampling pre-edge values, so stages shift together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      // NOTE: the data word is reset too, because the visible product must read zero after reset.
      q       <= '0;
    end else if (adv) begin
      q_valid <= d_valid;
      if (d_valid) q <= d;
    end
  end

endmodule

// File: rtl/premul_for_1213.sv
// Two-stage a*b front end for the q=1213 Barrett reducer, valid/ready on both sides.
// Optional operand range checking is enabled by defining PREMUL_RANGE_CHECK_EN.
module premul_for_1213
  import galois_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_1213-1:0]  in_a,
  input  logic [W_1213-1:0]  in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PW_1213-1:0] out_p,
  output logic               err_pulse,
  output logic [15:0]        err_count
);

  logic               adv1, adv2;
  logic               in_fire;
  logic               pair_ok;
  logic               s1_valid, s2_valid;
  s1_t                s1_d, s1_q;
  logic [PW_1213-1:0] s2_d;

  // A stage may load whenever the stage below it is empty or draining.
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1 && rst_n;
  assign in_fire  = in_valid && in_ready;

  // NOTE: every field gets a value on every path, so no latch is inferred.
  always_comb begin
    s1_d.a  = in_a;
    s1_d.b  = in_b;
    s1_d.pl = PL_W'(in_a) * PL_W'(in_b[B_SPLIT-1:0]);
    s1_d.ph = PH_W'(in_a) * PH_W'(in_b[W_1213-1:B_SPLIT]);
  end

  premul_stage_reg #(.DW($bits(s1_t))) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (adv1),
    .d_valid (in_fire && pair_ok),
    .d       (s1_d),
    .q_valid (s1_valid),
    .q       (s1_q)
  );

  // Recombine the partials; the top bit of ph only matters for out-of-range operands.
  assign s2_d = PW_1213'(s1_q.pl) + PW_1213'({s1_q.ph, {B_SPLIT{1'b0}}});

  premul_stage_reg #(.DW(PW_1213)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (adv2),
    .d_valid (s1_valid),
    .d       (s2_d),
    .q_valid (s2_valid),
    .q       (out_p)
  );

  assign out_valid = s2_valid;

  // The registered operands are kept for visibility only.
  logic unused_s1_bits;
  assign unused_s1_bits = ^{s1_q.a, s1_q.b};

`ifdef PREMUL_RANGE_CHECK_EN
  // A bad pair is still consumed, but enters S1 as a bubble.
  assign pair_ok = in_range_1213(in_a) && in_range_1213(in_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= in_fire && !pair_ok;
      if (in_fire && !pair_ok && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`else
  assign pair_ok   = 1'b1;
  assign err_pulse = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_premul_for_1213.sv
// Directed and constrained-random bench for premul_for_1213 with a queue-based product model.
module tb_premul_for_1213;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [10:0] in_a = '0;
  logic [10:0] in_b = '0;
  logic        in_ready, out_valid, err_pulse;
  logic [20:0] out_p;
  logic [15:0] err_count;

  premul_for_1213 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: products in acceptance order; bad pairs only count errors when checking is built in.
  function automatic bit is_bad(input logic [10:0] a, input logic [10:0] b);
`ifdef PREMUL_RANGE_CHECK_EN
    return (a >= 11'd1213) || (b >= 11'd1213);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned product(input logic [10:0] a, input logic [10:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p % (32'd1 << 21);
  endfunction

  int unsigned exp_q[$];
  int unsigned model_err = 0;
  bit          pend_err  = 1'b0;
  bit          hold_prev = 1'b0;
  logic [20:0] held_p    = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 0);
      exp_q.delete();
      model_err = 0;
      pend_err  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_p", out_p, held_p);
      end
      check("err_pulse", err_pulse, pend_err);
      check("err_count", err_count, model_err);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_beat", out_valid, 0);
        else check("out_p", out_p, exp_q.pop_front());
      end
      pend_err = 1'b0;
      if (in_valid && in_ready) begin
        if (is_bad(in_a, in_b)) begin
          pend_err = 1'b1;
          if (model_err != 65535) model_err++;
        end else begin
          exp_q.push_back(product(in_a, in_b));
        end
      end
      hold_prev = out_valid && !out_ready;
      held_p    = out_p;
    end
  end

  logic [10:0] a2 [4] = '{11'd1, 11'd2, 11'd0, 11'd1212};
  logic [10:0] b2 [4] = '{11'd1, 11'd3, 11'd1000, 11'd1};
  int unsigned p2 [4] = '{1, 6, 0, 1212};
  logic [10:0] a3 [4] = '{11'd10, 11'd30, 11'd50, 11'd70};
  logic [10:0] b3 [4] = '{11'd20, 11'd40, 11'd60, 11'd80};

  initial begin
    int  idx;
    bit  acc;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_ready_low", in_ready, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_release_ready", in_ready, 1);

    // Largest in-range product and its latency
    in_valid = 1'b1; in_a = 11'd1212; in_b = 11'd1212;
    tick();
    in_valid = 1'b0;
    check("t1_valid_early", out_valid, 0);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_p", out_p, 1468944);
    tick();
    check("t1_valid_after", out_valid, 0);

    // Back-to-back pairs at full rate
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_a = a2[c]; in_b = b2[c];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1 && c <= 4) begin
        check("t2_valid", out_valid, 1);
        check("t2_p", out_p, p2[c-1]);
      end
    end

    // Downstream stall fills the two stages, then drains in order
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_a = a3[idx]; in_b = b3[idx];
      #1;
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    check("t3_accepts", idx, 2);
    check("t3_in_ready", in_ready, 0);
    check("t3_out_valid", out_valid, 1);
    check("t3_hold_p", out_p, 200);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && idx < 4; c++) begin
      in_a = a3[idx]; in_b = b3[idx];
      #1;
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("t3_all_accepted", idx, 4);
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
    check("t3_drained", exp_q.size(), 0);

    // Reset while a product is waiting at the output
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 11'd7; in_b = 11'd9;
    tick();
    in_valid = 1'b0;
    tick();
    check("t4_pre_valid", out_valid, 1);
    check("t4_pre_p", out_p, 63);
    rst_n = 1'b0;
    tick();
    check("t4_out_valid", out_valid, 0);
    check("t4_out_p", out_p, 0);
    check("t4_err_count", err_count, 0);
    check("t4_ready_low", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("t4_ready_back", in_ready, 1);
    out_ready = 1'b1;

    // Out-of-range operand followed by a good pair
    in_valid = 1'b1; in_a = 11'd1213; in_b = 11'd5;
    tick();
`ifdef PREMUL_RANGE_CHECK_EN
    check("t5_err_pulse", err_pulse, 1);
    check("t5_err_count", err_count, 1);
`else
    check("t5_err_pulse", err_pulse, 0);
    check("t5_err_count", err_count, 0);
`endif
    in_a = 11'd2; in_b = 11'd2;
    tick();
    in_valid = 1'b0;
    check("t5_err_pulse_clear", err_pulse, 0);
`ifdef PREMUL_RANGE_CHECK_EN
    check("t5_no_beat", out_valid, 0);
`else
    check("t5_pass_valid", out_valid, 1);
    check("t5_pass_p", out_p, 6065);
`endif
    tick();
    check("t5_good_valid", out_valid, 1);
    check("t5_good_p", out_p, 4);
    tick();

    // Random traffic with random back-pressure; the model checks every beat
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        in_a = 11'($urandom_range(1213, 2047));
        in_b = 11'($urandom_range(0, 2047));
      end else begin
        in_a = 11'($urandom_range(0, 1212));
        in_b = 11'($urandom_range(0, 1212));
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    check("final_drained", exp_q.size(), 0);
    tick();
    check("final_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
